intersection_phase_arbiter: RTL and testbench



---
 rtl/intersection_phase_arbiter.sv | 130 +++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: round-robin phase scheduler for main road A, side road B and pedestrians
module intersection_phase_arbiter #(
  parameter int TICK_DIV    = 5,
  parameter int MIN_GREEN_A = 10,
  parameter int GREEN_B     = 8,
  parameter int WALK_T      = 6,
  parameter int AMBER_T     = 3,
  parameter int ALL_RED_T   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_b,
  input  logic       req_ped,
  input  logic       emg_a,
  output logic       red_a,
  output logic       amber_a,
  output logic       green_a,
  output logic       red_b,
  output logic       amber_b,
  output logic       green_b,
  output logic       walk,
  output logic [2:0] phase,
  output logic [6:0] countdown,
  output logic       b_pending,
  output logic       ped_pending
);
  typedef enum logic [2:0] {
    A_GREEN  = 3'd0,
    A_AMBER  = 3'd1,
    ALL_RED1 = 3'd2,
    B_GREEN  = 3'd3,
    B_AMBER  = 3'd4,
    PED_WALK = 3'd5,
    ALL_RED2 = 3'd6
  } phase_t;

  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;

  function automatic logic [6:0] dur(input phase_t p);
    case (p)
      A_GREEN:           dur = 7'(MIN_GREEN_A);
      A_AMBER, B_AMBER:  dur = 7'(AMBER_T);
      B_GREEN:           dur = 7'(GREEN_B);
      PED_WALK:          dur = 7'(WALK_T);
      default:           dur = 7'(ALL_RED_T);
    endcase
  endfunction

  // bit order: red_a amber_a green_a red_b amber_b green_b walk
  function automatic logic [6:0] lamps(input phase_t p);
    case (p)
      A_GREEN:  lamps = 7'b0011000;
      A_AMBER:  lamps = 7'b0101000;
      B_GREEN:  lamps = 7'b1000010;
      B_AMBER:  lamps = 7'b1000100;
      PED_WALK: lamps = 7'b1001001;
      default:  lamps = 7'b1001000;
    endcase
  endfunction

  phase_t          phase_q, phase_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic [6:0]      countdown_q, countdown_d;
  logic            b_pending_q, b_pending_d;
  logic            ped_pending_q, ped_pending_d;
  logic            rr_ptr_q, rr_ptr_d;
  logic [6:0]      lights_q, lights_d;
  logic            sec_tick, expire, change;

  always_comb begin
    sec_tick = presc_q == PW'(TICK_DIV - 1);
    expire   = sec_tick && countdown_q == 7'd1;
    phase_d  = phase_q;
    rr_ptr_d = rr_ptr_q;
    case (phase_q)
      A_GREEN:  phase_d = (countdown_q == 7'd0 && (b_pending_q || ped_pending_q) && !emg_a) ? A_AMBER : A_GREEN;
      A_AMBER:  phase_d = expire ? ALL_RED1 : A_AMBER;
      ALL_RED1: if (expire) begin
        // rr_ptr=0 favours B when both wait; the grant hands priority to the other side
        if (b_pending_q && (!ped_pending_q || !rr_ptr_q)) begin
          phase_d  = B_GREEN;
          rr_ptr_d = 1'b1;
        end else if (ped_pending_q) begin
          phase_d  = PED_WALK;
          rr_ptr_d = 1'b0;
        end else begin
          phase_d  = ALL_RED2;
        end
      end
      B_GREEN:  phase_d = (expire || emg_a) ? B_AMBER : B_GREEN;
      B_AMBER:  phase_d = expire ? ALL_RED2 : B_AMBER;
      PED_WALK: phase_d = (expire || emg_a) ? ALL_RED2 : PED_WALK;
      ALL_RED2: phase_d = expire ? A_GREEN : ALL_RED2;
      default:  phase_d = A_GREEN;
    endcase
    change        = phase_d != phase_q;
    presc_d       = (change || sec_tick) ? '0 : presc_q + PW'(1);
    countdown_d   = change ? dur(phase_d) :
                    (sec_tick && countdown_q != 7'd0) ? countdown_q - 7'd1 : countdown_q;
    b_pending_d   = (b_pending_q || req_b) && !(change && phase_d == B_GREEN);
    ped_pending_d = (ped_pending_q || req_ped) && !(change && phase_d == PED_WALK);
    lights_d      = lamps(phase_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q       <= A_GREEN;
      presc_q       <= '0;
      countdown_q   <= 7'(MIN_GREEN_A);
      b_pending_q   <= 1'b0;
      ped_pending_q <= 1'b0;
      rr_ptr_q      <= 1'b0;
      lights_q      <= lamps(A_GREEN);
    end else begin
      phase_q       <= phase_d;
      presc_q       <= presc_d;
      countdown_q   <= countdown_d;
      b_pending_q   <= b_pending_d;
      ped_pending_q <= ped_pending_d;
      rr_ptr_q      <= rr_ptr_d;
      lights_q      <= lights_d;
    end
  end

  assign {red_a, amber_a, green_a, red_b, amber_b, green_b, walk} = lights_q;
  assign phase       = phase_q;
  assign countdown   = countdown_q;
  assign b_pending   = b_pending_q;
  assign ped_pending = ped_pending_q;
endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// tb_intersection_phase_arbiter: random stimulus against a cycle-elapsed reference model with a scoreboard queue
module tb_intersection_phase_arbiter;
  localparam int TD = 5, MG = 10, GB = 8, WT = 6, AT = 3, AR = 1;
  localparam int N = 6000;

  logic clk = 1'b0, rst = 1'b1, req_b = 1'b0, req_ped = 1'b0, emg_a = 1'b0;
  logic red_a, amber_a, green_a, red_b, amber_b, green_b, walk;
  logic [2:0] phase;
  logic [6:0] countdown;
  logic b_pending, ped_pending;

  intersection_phase_arbiter #(
    .TICK_DIV(TD), .MIN_GREEN_A(MG), .GREEN_B(GB), .WALK_T(WT), .AMBER_T(AT), .ALL_RED_T(AR)
  ) dut (
    .clk(clk), .rst(rst), .req_b(req_b), .req_ped(req_ped), .emg_a(emg_a),
    .red_a(red_a), .amber_a(amber_a), .green_a(green_a),
    .red_b(red_b), .amber_b(amber_b), .green_b(green_b), .walk(walk),
    .phase(phase), .countdown(countdown), .b_pending(b_pending), .ped_pending(ped_pending)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] ph;
    logic [6:0] cd;
    logic [6:0] lights;
    logic       bp;
    logic       pp;
  } exp_t;

  exp_t q[$];
  int total = 0, bad = 0;
  int m_ph = 0, m_el = 0;
  bit m_bp = 0, m_pp = 0, m_rr = 0;

  function automatic int dur_s(input int p);
    case (p)
      0: return MG;
      1, 4: return AT;
      3: return GB;
      5: return WT;
      default: return AR;
    endcase
  endfunction

  function automatic logic [6:0] lt(input int p);
    case (p)
      0: return 7'b0011000;
      1: return 7'b0101000;
      3: return 7'b1000010;
      4: return 7'b1000100;
      5: return 7'b1001001;
      default: return 7'b1001000;
    endcase
  endfunction

  // seconds remaining derived from cycles spent in the phase
  function automatic int cd_of();
    int r;
    r = dur_s(m_ph) - m_el / TD;
    return r > 0 ? r : 0;
  endfunction

  task automatic step();
    int nx;
    bit ex;
    if (rst) begin
      m_ph = 0; m_el = 0; m_bp = 0; m_pp = 0; m_rr = 0;
    end else begin
      nx = m_ph;
      ex = (m_el + 1 == dur_s(m_ph) * TD);
      case (m_ph)
        0: if (cd_of() == 0 && (m_bp || m_pp) && !emg_a) nx = 1;
        1: if (ex) nx = 2;
        2: if (ex) begin
          if (m_bp && (!m_pp || !m_rr)) begin nx = 3; m_rr = 1; end
          else if (m_pp) begin nx = 5; m_rr = 0; end
          else nx = 6;
        end
        3: if (ex || emg_a) nx = 4;
        4: if (ex) nx = 6;
        5: if (ex || emg_a) nx = 6;
        default: if (ex) nx = 0;
      endcase
      m_bp = (m_bp || req_b) && !(nx == 3 && m_ph != 3);
      m_pp = (m_pp || req_ped) && !(nx == 5 && m_ph != 5);
      m_el = (nx != m_ph) ? 0 : m_el + 1;
      m_ph = nx;
    end
    q.push_back('{ph: 3'(m_ph), cd: 7'(cd_of()), lights: lt(m_ph), bp: m_bp, pp: m_pp});
  endtask

  task automatic chk(input string n, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s @%0t got=%0d want=%0d", n, $time, got, want);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("phase", int'(phase), int'(e.ph));
      chk("countdown", int'(countdown), int'(e.cd));
      chk("lights", int'({red_a, amber_a, green_a, red_b, amber_b, green_b, walk}), int'(e.lights));
      chk("b_pending", int'(b_pending), int'(e.bp));
      chk("ped_pending", int'(ped_pending), int'(e.pp));
      chk("one_lamp_a", $countones({red_a, amber_a, green_a}), 1);
      chk("one_lamp_b", $countones({red_b, amber_b, green_b}), 1);
      chk("walk_only_ped", int'(walk), int'(phase == 3'd5));
    end
  end

  initial begin
    bit did_ped_rst = 0;
    int rb, rp;
    for (int c = 0; c < N; c++) begin
      @(negedge clk);
      rb = (c / 1500 == 1) ? 2 : (c / 1500 == 2) ? 0 : (c / 1500 == 3) ? 5 : 1;
      rp = (c / 1500 == 1) ? 0 : (c / 1500 == 2) ? 2 : (c / 1500 == 3) ? 5 : 1;
      if (c < 2) begin
        rst = 1; req_b = 0; req_ped = 0; emg_a = 0;
      end else if (c < 300) begin
        rst = 0; req_ped = 0; emg_a = 0;
        req_b = (c == 210);
      end else begin
        req_b   = $urandom_range(0, 99) < rb;
        req_ped = $urandom_range(0, 99) < rp;
        if ($urandom_range(0, 199) == 0) emg_a = ~emg_a;
        rst = ($urandom_range(0, 1999) == 0);
        if (m_ph == 5 && m_el == 10 && !did_ped_rst) begin
          rst = 1;
          did_ped_rst = 1;
        end
      end
      step();
    end
    @(negedge clk);
    @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
